nubus_cpu_bridge: RTL

- Processor-side request buffer that sits directly upstream of the NuBus top-level master port.
- Accepts processor read/write requests through a valid/ready interface and queues them in a small FIFO.
- Presents one transaction at a time on the cpu_valid/addr/wdata/write/lock signals of the NuBus block and waits for its ready.
- Returns read data or a timeout error through a response valid/ready interface.

---
 rtl/nubus_bridge_pkg.sv | 20 ++
 rtl/nubus_req_fifo.sv | 54 +++++
 rtl/nubus_cpu_bridge.sv | 127 ++++++++++++
 3 files changed

// File: rtl/nubus_bridge_pkg.sv
// Shared types for the processor-to-NuBus request bridge.
package nubus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        lock;
  } req_entry_t;

  localparam int TIMER_W = 16;
  localparam int ENTRY_W = $bits(req_entry_t);

endpackage

// File: rtl/nubus_req_fifo.sv
// Synchronous request FIFO; pushes while full and pops while empty are ignored.
module nubus_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nubus_cpu_bridge.sv
// Queues processor requests and runs them one at a time against the NuBus master port.
module nubus_cpu_bridge
  import nubus_bridge_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        nub_clkn,
  input  logic        nub_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic        req_lock,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_write,
  output logic        bus_lock,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  // Timeout fires on the edge that would bring the timer up to TIMEOUT.
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               cur_lock;
  req_entry_t         push_entry;
  req_entry_t         head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;

  assign push_entry = '{addr: req_addr, wdata: req_wdata, wstrb: req_wstrb, lock: req_lock};
  assign req_ready  = !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;

  nubus_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (nub_clkn),
    .rst_n     (nub_resetn),
    .push      (req_valid),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state     <= IDLE;
      timer     <= '0;
      cur_lock  <= 1'b0;
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_write <= '0;
      bus_lock  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            bus_valid <= 1'b1;
            bus_addr  <= head.addr;
            bus_wdata <= head.wdata;
            bus_write <= head.wstrb;
            cur_lock  <= head.lock;
            // A lock held over from a completed locked entry stays asserted.
            bus_lock  <= bus_lock | head.lock;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          if (bus_ready) begin
            rsp_rdata <= (bus_write == '0) ? bus_rdata : '0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            bus_lock  <= cur_lock;
            bus_valid <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_write <= '0;
            state     <= RESP;
          end else begin
            if (timer != '1) timer <= timer + TIMER_W'(1);
            if (timer >= TIMEOUT_LAST) begin
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              bus_lock  <= 1'b0;
              bus_valid <= 1'b0;
              bus_addr  <= '0;
              bus_wdata <= '0;
              bus_write <= '0;
              state     <= RESP;
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            timer     <= '0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
